// File: rtl/mib_mc_arb_pkg.sv
// Shared types and helpers for the MIB multi-port request arbiter and its tag FIFO.
package mib_mc_arb_pkg;

    localparam int ARB_PORT_ID_W = 3;
    localparam int ARB_OCC_W     = 6;
    localparam int ARB_ADDR_W    = 36;
    localparam int ARB_DATA_W    = 128;
    localparam int ARB_BE_W      = ARB_DATA_W / 8;

    // Wide enough for the largest supported port count (8) and FIFO depth (32).
    typedef logic [ARB_PORT_ID_W-1:0] port_id_t;
    typedef logic [ARB_OCC_W-1:0]     occ_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  rnw;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_DATA_W-1:0] data;
    } mib_req_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mib_mc_tag_fifo.sv
// In-order FIFO of requesting port IDs for outstanding reads; push, pop, count, full, empty.
module mib_mc_tag_fifo
    import mib_mc_arb_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int ID_W  = 1,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [ID_W-1:0]  push_id_i,
    input  logic             pop_i,
    output logic [ID_W-1:0]  head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mib_mc_port_arbiter.sv
// N-port round-robin front end for the DDR2 controller MIB request channel with read-tag steering.
// Optional bank/row conflict hints are built when MIB_MC_ARB_CONFLICT_EN is defined.
module mib_mc_port_arbiter
    import mib_mc_arb_pkg::*;
#(
    parameter  int C_NUM_PORTS          = 2,
    parameter  int C_PORT_ID_WIDTH      = 1,
    parameter  int C_ADDR_WIDTH         = 36,
    parameter  int C_DATA_WIDTH         = 128,
    parameter  int C_MAX_RD_OUTSTANDING = 8,
    parameter  int C_BANK_LSB           = 13,
    parameter  int C_BANK_WIDTH         = 2,
    parameter  int C_ROW_LSB            = 15,
    parameter  int C_ROW_WIDTH          = 13,
    localparam int C_BE_WIDTH           = C_DATA_WIDTH / 8,
    localparam int C_OCC_WIDTH          = clog2(C_MAX_RD_OUTSTANDING) + 1
) (
    input  logic                                mc_mibclk,
    input  logic                                mi_mcreset_n,
    input  logic [C_NUM_PORTS-1:0]              p_addrvalid,
    input  logic [C_NUM_PORTS*C_ADDR_WIDTH-1:0] p_address,
    input  logic [C_NUM_PORTS-1:0]              p_readnotwrite,
    input  logic [C_NUM_PORTS*C_BE_WIDTH-1:0]   p_byteenable,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] p_writedata,
    output logic [C_NUM_PORTS-1:0]              p_addrack,
    output logic [C_DATA_WIDTH-1:0]             p_readdata,
    output logic [C_NUM_PORTS-1:0]              p_readdatavalid,
    output logic [C_NUM_PORTS-1:0]              p_readdataerr,
    output logic                                mi_mcaddressvalid,
    output logic [C_ADDR_WIDTH-1:0]             mi_mcaddress,
    output logic                                mi_mcreadnotwrite,
    output logic [C_BE_WIDTH-1:0]               mi_mcbyteenable,
    output logic [C_DATA_WIDTH-1:0]             mi_mcwritedata,
    output logic                                mi_mcwritedatavalid,
    output logic                                mi_mcbankconflict,
    output logic                                mi_mcrowconflict,
    input  logic                                mc_miaddrreadytoaccept,
    input  logic [C_DATA_WIDTH-1:0]             mc_mireaddata,
    input  logic                                mc_mireaddatavalid,
    input  logic                                mc_mireaddataerr,
    output logic [C_OCC_WIDTH-1:0]              rd_outstanding,
    output logic                                rd_underflow
);

    if (C_PORT_ID_WIDTH < 1 || (1 << C_PORT_ID_WIDTH) < C_NUM_PORTS ||
        C_BANK_LSB + C_BANK_WIDTH > C_ADDR_WIDTH || C_ROW_LSB + C_ROW_WIDTH > C_ADDR_WIDTH) begin : g_cfg_check
        $error("mib_mc_port_arbiter: inconsistent port-ID or bank/row field parameters");
    end

    typedef struct packed {
        logic [C_ADDR_WIDTH-1:0] addr;
        logic                    rnw;
        logic [C_BE_WIDTH-1:0]   be;
        logic [C_DATA_WIDTH-1:0] data;
    } req_t;

    req_t     req_q, req_d, sel_req;
    logic     valid_q, valid_d;
    port_id_t last_q, last_d, grant_idx;
    logic     grant_found, load_en, take;

    logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [C_PORT_ID_WIDTH-1:0] fifo_head;
    logic [C_OCC_WIDTH-1:0]     fifo_count;

    logic [C_DATA_WIDTH-1:0] rdata_q;
    logic [C_NUM_PORTS-1:0]  rdv_q, rdv_d, rderr_q, rderr_d;
    logic                    underflow_q;

    // The holding stage may take a new request when empty or emptying this cycle.
    assign load_en = ~valid_q | mc_miaddrreadytoaccept;
    assign take    = load_en & grant_found & mi_mcreset_n;

    always_comb begin
        int p;
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_req     = '0;
        p           = 0;
        for (int k = 0; k < C_NUM_PORTS; k++) begin
            p = (int'(last_q) + 1 + k) % C_NUM_PORTS;
            if (!grant_found && p_addrvalid[p] && (!p_readnotwrite[p] || !fifo_full)) begin
                grant_found  = 1'b1;
                grant_idx    = port_id_t'(p);
                sel_req.addr = p_address[p*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                sel_req.rnw  = p_readnotwrite[p];
                sel_req.be   = p_byteenable[p*C_BE_WIDTH +: C_BE_WIDTH];
                sel_req.data = p_writedata[p*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        last_d  = last_q;
        if (load_en) begin
            valid_d = grant_found;
            if (grant_found) begin
                req_d  = sel_req;
                last_d = grant_idx;
            end
        end
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            p_addrack[i] = take && (grant_idx == port_id_t'(i));
            rdv_d[i]     = fifo_pop && (fifo_head == C_PORT_ID_WIDTH'(i));
            rderr_d[i]   = rdv_d[i] && mc_mireaddataerr;
        end
    end

    always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
        if (!mi_mcreset_n) begin
            valid_q     <= 1'b0;
            req_q       <= '0;
            last_q      <= '0;
            rdata_q     <= '0;
            rdv_q       <= '0;
            rderr_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
            last_q  <= last_d;
            rdv_q   <= rdv_d;
            rderr_q <= rderr_d;
            if (fifo_pop) rdata_q <= mc_mireaddata;
            if (mc_mireaddatavalid && fifo_empty) underflow_q <= 1'b1;
        end
    end

    // Reads are tagged at grant time; returns pop in issue order.
    assign fifo_push = take & sel_req.rnw;
    assign fifo_pop  = mc_mireaddatavalid & ~fifo_empty;

    mib_mc_tag_fifo #(
        .DEPTH (C_MAX_RD_OUTSTANDING),
        .ID_W  (C_PORT_ID_WIDTH)
    ) u_tag_fifo (
        .clk       (mc_mibclk),
        .rst_n     (mi_mcreset_n),
        .push_i    (fifo_push),
        .push_id_i (C_PORT_ID_WIDTH'(grant_idx)),
        .pop_i     (fifo_pop),
        .head_o    (fifo_head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

`ifdef MIB_MC_ARB_CONFLICT_EN
    logic                    hist_vld_q, ref_vld, bank_hit, row_miss, transfer;
    logic [C_BANK_WIDTH-1:0] hist_bank_q, ref_bank;
    logic [C_ROW_WIDTH-1:0]  hist_row_q, ref_row;
    logic                    bank_conf_q, row_conf_q;

    assign transfer = valid_q & mc_miaddrreadytoaccept;

    // A request leaving this cycle is the predecessor of the one being loaded.
    always_comb begin
        ref_vld  = hist_vld_q;
        ref_bank = hist_bank_q;
        ref_row  = hist_row_q;
        if (transfer) begin
            ref_vld  = 1'b1;
            ref_bank = req_q.addr[C_BANK_LSB +: C_BANK_WIDTH];
            ref_row  = req_q.addr[C_ROW_LSB +: C_ROW_WIDTH];
        end
        bank_hit = ref_vld && (sel_req.addr[C_BANK_LSB +: C_BANK_WIDTH] == ref_bank);
        row_miss = bank_hit && (sel_req.addr[C_ROW_LSB +: C_ROW_WIDTH] != ref_row);
    end

    always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
        if (!mi_mcreset_n) begin
            hist_vld_q  <= 1'b0;
            hist_bank_q <= '0;
            hist_row_q  <= '0;
            bank_conf_q <= 1'b0;
            row_conf_q  <= 1'b0;
        end else begin
            if (transfer) begin
                hist_vld_q  <= 1'b1;
                hist_bank_q <= req_q.addr[C_BANK_LSB +: C_BANK_WIDTH];
                hist_row_q  <= req_q.addr[C_ROW_LSB +: C_ROW_WIDTH];
            end
            if (load_en) begin
                bank_conf_q <= take & bank_hit;
                row_conf_q  <= take & row_miss;
            end
        end
    end

    assign mi_mcbankconflict = bank_conf_q;
    assign mi_mcrowconflict  = row_conf_q;
`else
    assign mi_mcbankconflict = 1'b0;
    assign mi_mcrowconflict  = 1'b0;
`endif

    assign mi_mcaddressvalid   = valid_q;
    assign mi_mcaddress        = req_q.addr;
    assign mi_mcreadnotwrite   = req_q.rnw;
    assign mi_mcbyteenable     = req_q.be;
    assign mi_mcwritedata      = req_q.data;
    assign mi_mcwritedatavalid = valid_q & ~req_q.rnw;
    assign p_readdata          = rdata_q;
    assign p_readdatavalid     = rdv_q;
    assign p_readdataerr       = rderr_q;
    assign rd_outstanding      = fifo_count;
    assign rd_underflow        = underflow_q;

endmodule
